// File: rtl/led_pattern_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : led_pattern_sequencer
//  Description : Prescaled LED pattern shifter (rotate left/right, bounce,
//                freeze) with parallel load.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_sequencer #(
    parameter int                NB_LED       = 4,
    parameter int                PRESC_MAX    = 12_500_000,
    parameter logic [NB_LED-1:0] INIT_PATTERN = 'b1
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic [1:0]        i_mode,
    input  logic              i_load,
    input  logic [NB_LED-1:0] i_pattern,
    output logic [NB_LED-1:0] o_led,
    output logic              o_step,
    output logic              o_dir
);

    localparam int                  c_cnt_w    = (PRESC_MAX > 1) ? $clog2(PRESC_MAX) : 1;
    localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(PRESC_MAX - 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);
    localparam logic [1:0]          c_mode_rotl   = 2'b00;
    localparam logic [1:0]          c_mode_rotr   = 2'b01;
    localparam logic [1:0]          c_mode_bounce = 2'b10;
    localparam logic [1:0]          c_mode_freeze = 2'b11;

    typedef enum logic [0:0] {
        S_LEFT  = 1'b0,
        S_RIGHT = 1'b1
    } dir_state_t;

    logic [c_cnt_w-1:0] r_count;
    logic [NB_LED-1:0]  r_led;
    logic               r_step;
    dir_state_t         r_dir;

    logic               w_advance;
    logic               w_tick;
    logic [NB_LED-1:0]  w_next_led;
    dir_state_t         w_next_dir;

    assign w_advance = i_valid && (i_mode != c_mode_freeze);
    assign w_tick    = w_advance && (r_count == c_cnt_last);

    // Pattern and bounce direction that a tick would commit this cycle.
    always_comb begin
        w_next_led = r_led;
        w_next_dir = r_dir;
        case (i_mode)
            c_mode_rotl: w_next_led = {r_led[NB_LED-2:0], r_led[NB_LED-1]};
            c_mode_rotr: w_next_led = {r_led[0], r_led[NB_LED-1:1]};
            c_mode_bounce: begin
                if (r_dir == S_LEFT) begin
                    if (r_led[NB_LED-1]) begin
                        w_next_dir = S_RIGHT;
                        w_next_led = {1'b0, r_led[NB_LED-1:1]};
                    end else begin
                        w_next_led = {r_led[NB_LED-2:0], 1'b0};
                    end
                end else begin
                    if (r_led[0]) begin
                        w_next_dir = S_LEFT;
                        w_next_led = {r_led[NB_LED-2:0], 1'b0};
                    end else begin
                        w_next_led = {1'b0, r_led[NB_LED-1:1]};
                    end
                end
            end
            default: w_next_led = r_led;
        endcase
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_count <= '0;
            r_led   <= INIT_PATTERN;
            r_step  <= 1'b0;
            r_dir   <= S_LEFT;
        end else if (i_load) begin
            r_count <= '0;
            r_led   <= i_pattern;
            r_step  <= 1'b0;
            r_dir   <= S_LEFT;
        end else begin
            r_step <= w_tick;
            if (w_advance) begin
                r_count <= w_tick ? '0 : (r_count + c_cnt_one);
            end
            if (w_tick) begin
                r_led <= w_next_led;
                r_dir <= w_next_dir;
            end
        end
    end

    assign o_led  = r_led;
    assign o_step = r_step;
    assign o_dir  = r_dir;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_pattern_sequencer
//  Description : Directed self-checking bench for led_pattern_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pattern_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [1:0] mode;
    logic       load;
    logic [3:0] pattern;
    logic [3:0] led;
    logic       step;
    logic       dir;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_pattern_sequencer #(
        .NB_LED       (4),
        .PRESC_MAX    (3),
        .INIT_PATTERN (4'b0001)
    ) dut (
        .clock     (clk),
        .i_reset   (rst),
        .i_valid   (valid),
        .i_mode    (mode),
        .i_load    (load),
        .i_pattern (pattern),
        .o_led     (led),
        .o_step    (step),
        .o_dir     (dir)
    );

    task automatic edge_clk;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] exp_led,
                       input logic exp_step, input logic exp_dir);
        checks++;
        if (led !== exp_led || step !== exp_step || dir !== exp_dir) begin
            errors++;
            $display("FAIL %s: got led=%b step=%b dir=%b, expected led=%b step=%b dir=%b",
                     name, led, step, dir, exp_led, exp_step, exp_dir);
        end
    endtask

    task automatic do_reset;
        rst = 1'b1; load = 1'b0; edge_clk(); rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; valid = 1'b1; mode = 2'b00; load = 1'b0; pattern = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            edge_clk();
            chk("reset_hold", 4'b0001, 1'b0, 1'b0);
        end
        rst = 1'b0;
    endtask

    task automatic test_rotate_left;
        logic [3:0] exp_seq [4];
        logic [3:0] cur;
        exp_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        cur = 4'b0001;
        valid = 1'b1; mode = 2'b00;
        for (int s = 0; s < 4; s++) begin
            edge_clk(); chk("rotl_wait1", cur, 1'b0, 1'b0);
            edge_clk(); chk("rotl_wait2", cur, 1'b0, 1'b0);
            edge_clk(); cur = exp_seq[s]; chk("rotl_step", cur, 1'b1, 1'b0);
        end
    endtask

    task automatic test_rotate_right;
        logic [3:0] exp_seq [4];
        logic [3:0] cur;
        exp_seq = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        cur = 4'b0001;
        valid = 1'b1; mode = 2'b01;
        for (int s = 0; s < 4; s++) begin
            edge_clk(); edge_clk();
            chk("rotr_wait", cur, 1'b0, 1'b0);
            edge_clk(); cur = exp_seq[s]; chk("rotr_step", cur, 1'b1, 1'b0);
        end
        // mode change mid-count keeps the original schedule
        mode = 2'b00; edge_clk(); chk("midcount_1", 4'b0001, 1'b0, 1'b0);
        mode = 2'b01; edge_clk(); chk("midcount_2", 4'b0001, 1'b0, 1'b0);
        edge_clk(); chk("midcount_step", 4'b1000, 1'b1, 1'b0);
    endtask

    task automatic test_bounce;
        logic [3:0] exp_led [7];
        logic       exp_dir [7];
        logic [3:0] cur;
        logic       cd;
        exp_led = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        exp_dir = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        cur = 4'b0001; cd = 1'b0;
        valid = 1'b1; mode = 2'b10;
        for (int s = 0; s < 7; s++) begin
            edge_clk(); edge_clk();
            chk("bounce_wait", cur, 1'b0, cd);
            edge_clk(); cur = exp_led[s]; cd = exp_dir[s];
            chk("bounce_step", cur, 1'b1, cd);
        end
    endtask

    task automatic test_valid_freeze;
        do_reset();
        valid = 1'b1; mode = 2'b00;
        edge_clk(); edge_clk();
        valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            edge_clk(); chk("valid_low_quiet", 4'b0001, 1'b0, 1'b0);
        end
        valid = 1'b1; edge_clk(); chk("valid_resume_step", 4'b0010, 1'b1, 1'b0);
        mode = 2'b11;
        for (int i = 0; i < 10; i++) begin
            edge_clk(); chk("freeze_hold", 4'b0010, 1'b0, 1'b0);
        end
    endtask

    task automatic test_load_and_reset;
        do_reset();
        valid = 1'b1; mode = 2'b00;
        edge_clk(); edge_clk();
        load = 1'b1; pattern = 4'b0110;
        edge_clk(); chk("load_over_tick", 4'b0110, 1'b0, 1'b0);
        load = 1'b0;
        edge_clk(); edge_clk(); chk("load_wait", 4'b0110, 1'b0, 1'b0);
        edge_clk(); chk("load_first_step", 4'b1100, 1'b1, 1'b0);
        // bounce from a two-bit pattern with the MSB lit drops the low bit
        load = 1'b1; pattern = 4'b1001; edge_clk(); load = 1'b0;
        mode = 2'b10;
        edge_clk(); edge_clk(); edge_clk(); chk("bounce_1001", 4'b0100, 1'b1, 1'b1);
        // load clears direction back to S_LEFT
        load = 1'b1; pattern = 4'b0000; edge_clk(); load = 1'b0;
        chk("load_clears_dir", 4'b0000, 1'b0, 1'b0);
        edge_clk(); edge_clk(); edge_clk(); chk("bounce_zero", 4'b0000, 1'b1, 1'b0);
        // reset mid-bounce while heading right, mid-count
        do_reset();
        mode = 2'b10;
        for (int i = 0; i < 13; i++) edge_clk();
        chk("pre_reset_bounce", 4'b0100, 1'b0, 1'b1);
        rst = 1'b1; edge_clk(); rst = 1'b0;
        chk("reset_mid_bounce", 4'b0001, 1'b0, 1'b0);
        edge_clk(); edge_clk(); edge_clk(); chk("post_reset_step", 4'b0010, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_rotate_left();
        test_rotate_right();
        test_bounce();
        test_valid_freeze();
        test_load_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
